// File: rtl/bus_pkg.sv
// rtl/bus_pkg.sv - shared types and constants for the serial bus master port
//
// Contents:
//   state_t               FSM state encoding of burst_master_port
//   MODE_WRITE/MODE_READ  values of the bus direction bit
//   DEF_ADDR_W/DEF_DATA_W default address and data widths
package bus_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    WDATA,
    WLOAD,
    RDATA,
    ACK_WAIT
  } state_t;

  localparam logic MODE_WRITE = 1'b1;
  localparam logic MODE_READ  = 1'b0;

  localparam int DEF_ADDR_W = 16;
  localparam int DEF_DATA_W = 8;

endpackage

// File: rtl/burst_master_port_if.sv
// rtl/burst_master_port_if.sv - bit-serial system bus signals
//
// Signals:
//   mode          bus direction, 1 = write (master -> slave)
//   wr_bus        serial header / write-data bit, LSB first
//   master_valid  wr_bus bit valid (master -> slave)
//   slave_ready   slave accepts wr_bus bit (slave -> master)
//   rd_bus        serial read-data bit, LSB first (slave -> master)
//   slave_valid   rd_bus bit valid (slave -> master)
//   master_ready  master accepts rd_bus bit (master -> slave)
//   ack           end-of-transaction acknowledge (slave -> master)
interface burst_master_port_if;

  logic mode;
  logic wr_bus;
  logic master_valid;
  logic slave_ready;
  logic rd_bus;
  logic slave_valid;
  logic master_ready;
  logic ack;

  modport master (
    output mode, wr_bus, master_valid, master_ready,
    input  slave_ready, rd_bus, slave_valid, ack
  );

  modport slave (
    input  mode, wr_bus, master_valid, master_ready,
    output slave_ready, rd_bus, slave_valid, ack
  );

endinterface

// File: rtl/bus_shift_reg.sv
// rtl/bus_shift_reg.sv - parallel-load shift register, shifts towards bit 0
//
// Ports:
//   clk, rstn   clock, asynchronous active-low reset
//   load        parallel load of load_data (wins over shift_en)
//   load_data   parallel load value
//   shift_en    shift one place towards the LSB
//   ser_in      bit entering at the MSB on a shift
//   q           register contents; q[0] is the serial-out bit (LSB first)
module bus_shift_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             shift_en,
  input  logic             ser_in,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      q <= '0;
    end else if (load) begin
      q <= load_data;
    end else if (shift_en) begin
      q <= {ser_in, q[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/burst_master_port.sv
// rtl/burst_master_port.sv - bit-serial bus master with single/burst read and write
//
// Optional feature: define MASTER_PORT_TIMEOUT_EN to abort stalled transactions
// after TIMEOUT cycles (m_done + m_err). Without it the master waits forever.
//
// Ports:
//   clk, rstn    clock, asynchronous active-low reset
//   m_start      request, sampled in IDLE; m_mode/m_addr/m_len/m_wr_data captured with it
//   m_wr_data    write beat; m_wr_valid/m_wr_ready handshake for beats >= 1
//   m_rd_data    read beat, valid during the m_rd_valid pulse
//   m_busy       transaction in progress
//   m_done       completion pulse; m_err pulses with it on timeout abort
//   bus          serial system bus (master modport)
module burst_master_port
  import bus_pkg::*;
#(
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int MAX_BURST = 4,
  parameter int TIMEOUT   = 64
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         m_start,
  input  logic                         m_mode,
  input  logic [ADDR_W-1:0]            m_addr,
  input  logic [$clog2(MAX_BURST)-1:0] m_len,
  input  logic [DATA_W-1:0]            m_wr_data,
  input  logic                         m_wr_valid,
  output logic                         m_wr_ready,
  output logic [DATA_W-1:0]            m_rd_data,
  output logic                         m_rd_valid,
  output logic                         m_busy,
  output logic                         m_done,
  output logic                         m_err,
  burst_master_port_if.master          bus
);

  localparam int LEN_W = $clog2(MAX_BURST);
  localparam int HDR_W = ADDR_W + LEN_W;
  localparam int CNT_W = $clog2((HDR_W > DATA_W) ? HDR_W : DATA_W);
  localparam logic [CNT_W-1:0] HDR_LAST  = CNT_W'(HDR_W - 1);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);

  state_t           state;
  logic [CNT_W-1:0] bit_cnt;
  logic [LEN_W-1:0] beat_cnt;
  logic [LEN_W-1:0] len_r;
  logic             mode_r, mv_r, mr_r;
  logic [HDR_W-1:0] hdr_q;
  logic [DATA_W-1:0] wdata_q, rd_q;
  logic             wr_xfer, rd_xfer, timed_out;
  logic             unused_bits;

  assign wr_xfer = mv_r && bus.slave_ready;
  assign rd_xfer = mr_r && bus.slave_valid;

  assign bus.mode         = mode_r;
  assign bus.master_valid = mv_r;
  assign bus.master_ready = mr_r;
  // Gated by master_valid so the line idles low outside HDR/WDATA.
  assign bus.wr_bus       = mv_r && ((state == HDR) ? hdr_q[0] : wdata_q[0]);

  // Header: address in the low bits so it leaves first, then the length.
  bus_shift_reg #(.WIDTH(HDR_W)) u_hdr (
    .clk, .rstn,
    .load      (state == IDLE && m_start),
    .load_data ({m_len, m_addr}),
    .shift_en  (state == HDR && wr_xfer),
    .ser_in    (1'b0),
    .q         (hdr_q)
  );

  // Write beat 0 is loaded with the request, later beats in WLOAD.
  bus_shift_reg #(.WIDTH(DATA_W)) u_wdata (
    .clk, .rstn,
    .load      ((state == IDLE && m_start) || (state == WLOAD && m_wr_valid)),
    .load_data (m_wr_data),
    .shift_en  (state == WDATA && wr_xfer),
    .ser_in    (1'b0),
    .q         (wdata_q)
  );

  // Read assembly: bits enter at the MSB, so after DATA_W shifts bit 0 is the first bit.
  bus_shift_reg #(.WIDTH(DATA_W)) u_rdata (
    .clk, .rstn,
    .load      (1'b0),
    .load_data ('0),
    .shift_en  (state == RDATA && rd_xfer),
    .ser_in    (bus.rd_bus),
    .q         (rd_q)
  );

  assign unused_bits = ^{hdr_q[HDR_W-1:1], wdata_q[DATA_W-1:1], rd_q[0]};

`ifdef MASTER_PORT_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT + 1);
  logic [TMO_W-1:0] stall_cnt;
  logic             stall;

  // Every state change coincides with a transfer or with leaving to IDLE/WLOAD,
  // where stall is low, so clearing on !stall also clears on state changes.
  assign stall = ((state == HDR || state == WDATA) && !wr_xfer) ||
                 (state == RDATA && !rd_xfer) ||
                 (state == ACK_WAIT && !bus.ack);
  assign timed_out = stall && (stall_cnt == TMO_W'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      stall_cnt <= '0;
    end else if (!stall || timed_out) begin
      stall_cnt <= '0;
    end else begin
      stall_cnt <= stall_cnt + TMO_W'(1);
    end
  end
`else
  // No timeout hardware: constant false.
  assign timed_out = (TIMEOUT < 0);
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      beat_cnt   <= '0;
      len_r      <= '0;
      mode_r     <= 1'b0;
      mv_r       <= 1'b0;
      mr_r       <= 1'b0;
      m_wr_ready <= 1'b0;
      m_rd_data  <= '0;
      m_rd_valid <= 1'b0;
      m_busy     <= 1'b0;
      m_done     <= 1'b0;
      m_err      <= 1'b0;
    end else begin
      m_done     <= 1'b0;
      m_err      <= 1'b0;
      m_rd_valid <= 1'b0;
      if (timed_out) begin
        state   <= IDLE;
        bit_cnt <= '0;
        mv_r    <= 1'b0;
        mr_r    <= 1'b0;
        mode_r  <= 1'b0;
        m_busy  <= 1'b0;
        m_done  <= 1'b1;
        m_err   <= 1'b1;
      end else begin
        case (state)
          IDLE: if (m_start) begin
            state    <= HDR;
            mode_r   <= m_mode;
            len_r    <= m_len;
            beat_cnt <= '0;
            bit_cnt  <= '0;
            mv_r     <= 1'b1;
            m_busy   <= 1'b1;
          end
          HDR: if (wr_xfer) begin
            if (bit_cnt == HDR_LAST) begin
              bit_cnt <= '0;
              if (mode_r == MODE_WRITE) begin
                state <= WDATA;
              end else begin
                state <= RDATA;
                mv_r  <= 1'b0;
                mr_r  <= 1'b1;
              end
            end else begin
              bit_cnt <= bit_cnt + CNT_W'(1);
            end
          end
          WDATA: if (wr_xfer) begin
            if (bit_cnt == DATA_LAST) begin
              bit_cnt <= '0;
              mv_r    <= 1'b0;
              if (beat_cnt == len_r) begin
                state <= ACK_WAIT;
              end else begin
                state      <= WLOAD;
                m_wr_ready <= 1'b1;
                beat_cnt   <= beat_cnt + LEN_W'(1);
              end
            end else begin
              bit_cnt <= bit_cnt + CNT_W'(1);
            end
          end
          WLOAD: if (m_wr_valid) begin
            state      <= WDATA;
            m_wr_ready <= 1'b0;
            mv_r       <= 1'b1;
          end
          RDATA: if (rd_xfer) begin
            if (bit_cnt == DATA_LAST) begin
              bit_cnt    <= '0;
              m_rd_data  <= {bus.rd_bus, rd_q[DATA_W-1:1]};
              m_rd_valid <= 1'b1;
              if (beat_cnt == len_r) begin
                state <= ACK_WAIT;
                mr_r  <= 1'b0;
              end else begin
                beat_cnt <= beat_cnt + LEN_W'(1);
              end
            end else begin
              bit_cnt <= bit_cnt + CNT_W'(1);
            end
          end
          ACK_WAIT: if (bus.ack) begin
            state  <= IDLE;
            mode_r <= 1'b0;
            m_busy <= 1'b0;
            m_done <= 1'b1;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: doc/burst_master_port.md
# burst_master_port

Parametrised bit-serial bus master port supporting single and burst read/write transactions. It sits between a local requester (CPU/DMA side) and the serial system bus. It serialises a header of address plus burst length, then streams write data or collects read data, one bit per handshake. It extends the fixed 8-bit-data/16-bit-address single-transfer master with configurable widths, bursts, per-bit backpressure and an optional timeout.

## Interface
- ADDR_W, 16, address width in bits
- DATA_W, 8, data beat width in bits
- MAX_BURST, 4, maximum beats per transaction; power of 2, ≥2; localparam LEN_W = $clog2(MAX_BURST)
- TIMEOUT, 64, stall cycles before abort; only used with the timeout feature
- clk  in  1  clock; all logic on rising edge
- rstn  in  1  asynchronous, active-low reset
- m_start  in  1  transaction request; sampled only in IDLE
- m_mode  in  1  1 = write, 0 = read; captured with m_start
- m_addr  in  ADDR_W  start address; captured with m_start
- m_len  in  LEN_W  beat count minus 1; captured with m_start
- m_wr_data  in  DATA_W  write beat; beat 0 captured with m_start
- m_wr_valid  in  1  next write beat (beats ≥1) valid
- m_wr_ready  out  1  master can accept next write beat
- m_rd_data  out  DATA_W  read beat; valid while m_rd_valid
- m_rd_valid  out  1  one-cycle pulse per received read beat
- m_busy  out  1  high from the cycle after m_start until m_done
- m_done  out  1  one-cycle completion pulse
- m_err  out  1  one-cycle pulse together with m_done on timeout abort
- mode  out  1  bus direction; 1 = write; held for the whole transaction
- wr_bus  out  1  serial header/write-data bit, LSB first
- master_valid  out  1  wr_bus bit valid
- slave_ready  in  1  slave accepts wr_bus bit
- rd_bus  in  1  serial read-data bit, LSB first
- slave_valid  in  1  rd_bus bit valid
- master_ready  out  1  master accepts rd_bus bit
- ack  in  1  slave end-of-transaction acknowledge

## Operation
- States: IDLE, HDR, WDATA, WLOAD, RDATA, ACK_WAIT.
- A wr_bus bit transfers on each edge where master_valid && slave_ready.
- An rd_bus bit transfers on each edge where slave_valid && master_ready.
- IDLE: on m_start, capture all request fields and go to HDR. m_start is ignored in every other state.
- HDR: master_valid=1. Shift ADDR_W address bits, then LEN_W length bits, LSB first.
  - Write: go to WDATA.
  - Read: go to RDATA.
- WDATA: master_valid=1. Shift DATA_W bits of the current beat.
  - After the last bit: go to WLOAD if beats remain, else ACK_WAIT.
- WLOAD: master_valid=0, m_wr_ready=1. On m_wr_valid, capture m_wr_data and return to WDATA.
- RDATA: master_ready=1. Collect DATA_W bits.
  - On the last bit, register the word to m_rd_data and pulse m_rd_valid next cycle.
  - After the final beat: go to ACK_WAIT.
- ACK_WAIT: all handshake outputs 0. On ack=1, pulse m_done and go to IDLE.
- ack outside ACK_WAIT is ignored.
- wr_bus is 0 whenever master_valid=0.

## Timing
- Reset value of every output is 0. The FSM resets to IDLE.
- Reset mid-transaction aborts immediately: master_valid, master_ready and m_busy drop asynchronously, and no m_done is issued.
- Zero-stall write of N beats: first header bit is driven the cycle after m_start.
  - Bits transfer on the following ADDR_W+LEN_W+N·DATA_W edges, plus one WLOAD cycle per beat ≥1 when m_wr_valid is already high.
- m_done asserts the cycle after the edge sampling ack=1. m_busy falls in the same cycle.
- m_rd_valid asserts one cycle after the last bit of each beat. There is no local backpressure on reads.
- slave_ready=0 holds wr_bus and the bit counters unchanged. slave_valid=0 stalls read collection.

## Configuration
- MASTER_PORT_TIMEOUT_EN defined:
  - A stall counter increments every cycle in HDR/WDATA/RDATA without a bit transfer, and every cycle in ACK_WAIT.
  - The counter clears on every transfer and on each state change.
  - On reaching TIMEOUT, m_done and m_err pulse together and the FSM goes to IDLE.
  - WLOAD waits on the local side and is never timed.
- Undefined: no counter; the master waits indefinitely; m_err is tied 0.

## Structure
- Shared package bus_pkg:
  - State enum.
  - MODE_WRITE/MODE_READ constants.
  - Default ADDR_W/DATA_W constants.
- One sub-module bus_shift_reg, parametrised width, with a parallel load, a serial-out LSB-first port and a serial-in shift port.
- bus_shift_reg is used for the header and write path, and for read assembly.

## Test plan
- Single write, addr 0xabcd, data 0xd3, m_len 0, slave_ready=1, ack 3 cycles after the last bit:
  - wr_bus shows the 16 address bits LSB first, then 00, then 1,1,0,0,1,0,1,1.
  - m_done pulses one cycle after ack; mode=1 throughout.
- 4-beat write 0x11,0x22,0x33,0x44 with m_wr_valid low for 3 cycles before beat 2:
  - master_valid is low for exactly those cycles plus the WLOAD cycle.
  - 32 data bits arrive in order.
- 2-beat read, slave streams 0x5a then 0xa5 with slave_valid gaps:
  - m_rd_valid pulses twice, with m_rd_data 0x5a then 0xa5; mode=0.
- slave_ready toggled every other cycle during the header: each wr_bus bit is held until accepted, and the header takes 2×(ADDR_W+LEN_W) cycles.
- With MASTER_PORT_TIMEOUT_EN and TIMEOUT=64, ack never asserted: m_err and m_done pulse 64 cycles after entering ACK_WAIT, and the next m_start is accepted.
- rstn low in the middle of WDATA:
  - All outputs read 0 before the next clock edge.
  - After release, a new single write completes normally.
